trace_monitor: RTL

TRACE_MONITOR -- requirements
Module: trace_monitor

---
 rtl/trace_monitor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/trace_monitor.sv
// Trace monitor: logs valid PCs into a circular buffer while running and
// watches fetched instruction words for pass/fail signatures. A run-cycle
// timer flags TIMEOUT. The buffer can be read back at any time, oldest entry
// first, through a one-cycle registered read port.
module trace_monitor #(
    parameter int          XLEN       = 32,
    parameter int          DEPTH      = 16,
    parameter logic [31:0] PASS_VALUE = 32'h1,
    parameter logic [31:0] FAIL_VALUE = 32'h0,
    parameter int          TIMEOUT    = 50000,
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    input  logic [31:0]     iread_i,
    input  logic            iread_valid_i,
    input  logic            clear_i,
    input  logic [AW-1:0]   rd_idx_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic [AW:0]     count_o,
    output logic [1:0]      status_o,
    output logic            done_o
);

    // Timer must be able to hold TIMEOUT itself; a disabled timer keeps one idle bit.
    localparam int          TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [AW:0] FULL     = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW:0]     count_reg, count_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            wr_en;

    // Trace storage is deliberately left unreset; the count gates stale data.
    logic [XLEN-1:0] trace_mem [DEPTH];

    logic            pass_hit;
    logic            fail_hit;
    logic            tmo_hit;
    logic [AW-1:0]   rd_addr;
    logic            rd_hit;

    assign pass_hit = iread_valid_i && (iread_i == PASS_VALUE);
    assign fail_hit = iread_valid_i && (iread_i == FAIL_VALUE);
    assign tmo_hit  = (TIMEOUT > 0) && (timer_reg == TMO_LAST);

    // Oldest entry sits count slots behind the write pointer (mod DEPTH).
    assign rd_addr = wr_ptr_reg - count_reg[AW-1:0] + rd_idx_i;
    assign rd_hit  = ({1'b0, rd_idx_i} < count_reg);

    // State, pointer, count and timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_RUN;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            timer_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            timer_reg  <= timer_next;
        end
    end

    // Next-state logic: clear beats everything, pass/fail beats timeout,
    // and terminal states freeze the log and timer.
    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        timer_next  = timer_reg;
        wr_en       = 1'b0;
        if (clear_i) begin
            state_next  = ST_RUN;
            wr_ptr_next = '0;
            count_next  = '0;
            timer_next  = '0;
        end else if (state_reg == ST_RUN) begin
            if (pc_valid_i) begin
                wr_en       = 1'b1;
                wr_ptr_next = wr_ptr_reg + AW'(1);
                if (count_reg != FULL) begin
                    count_next = count_reg + (AW + 1)'(1);
                end
            end
            if (TIMEOUT > 0) begin
                timer_next = timer_reg + TW'(1);
            end
            if (pass_hit) begin
                state_next = ST_PASS;
            end else if (fail_hit) begin
                state_next = ST_FAIL;
            end else if (tmo_hit) begin
                state_next = ST_TIMEOUT;
            end
        end
    end

    // Buffer write port; overwrites the oldest slot once the log is full.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            trace_mem[wr_ptr_ptr_sel()] <= pc_i;
        end
    end

    function automatic logic [AW-1:0] wr_ptr_ptr_sel();
        return wr_ptr_reg;
    endfunction

    // Registered readout; indices beyond the valid count read as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_o <= '0;
        end else if (rd_hit) begin
            rd_data_o <= trace_mem[rd_addr];
        end else begin
            rd_data_o <= '0;
        end
    end

    assign count_o  = count_reg;
    assign status_o = state_reg;
    assign done_o   = (state_reg != ST_RUN);

endmodule
